// File: rtl/result_streamer_pkg.sv
// Shared definitions for the result streamer: default widths, latency counter width
// and the FSM state encoding.
package result_streamer_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    // Wide enough to count RAM_LATENCY values 1..3.
    localparam int LAT_W      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/result_streamer_if.sv
// Valid/ready result stream: one word with its index and a last marker per transfer.
interface result_streamer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) ();

    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data, out_index, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_index, out_last, out_valid,
        output out_ready
    );

endinterface

// File: rtl/result_streamer_argmax_tracker.sv
// Running signed maximum over sampled words. Only a strictly greater value replaces
// the current maximum, so ties keep the earliest index.
module argmax_tracker
    import result_streamer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] value,
    input  logic [ADDR_W-1:0] index,
    output logic [DATA_W-1:0] max_value,
    output logic [ADDR_W-1:0] max_index
);

    localparam logic [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] max_value_q;
    logic [ADDR_W-1:0] max_index_q;

    // NOTE: clocked state uses non-blocking assignments so every reader sees the
    // pre-edge value, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            max_value_q <= DATA_MIN;
            max_index_q <= '0;
        end else if (sample_en && ($signed(value) > $signed(max_value_q))) begin
            max_value_q <= value;
            max_index_q <= index;
        end
    end

    assign max_value = max_value_q;
    assign max_index = max_index_q;

endmodule

// File: rtl/result_streamer.sv
// Walks the accelerator's result words out of neuron RAM on each rising edge of
// acc_finished, streams them over valid/ready and publishes the signed argmax at run end.
module result_streamer
    import result_streamer_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int RAM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acc_finished,
    input  logic [ADDR_W-1:0]    acc_result_base,
    input  logic [ADDR_W-1:0]    acc_result_count,
    output logic [ADDR_W-1:0]    ram_read_adr,
    input  logic [DATA_W-1:0]    ram_read_data,
    result_streamer_if.master    out_if,
    output logic [ADDR_W-1:0]    argmax_index,
    output logic [DATA_W-1:0]    argmax_value,
    output logic                 busy,
    output logic                 done
);

    localparam logic [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RAM_LATENCY - 1);

    state_e            state_q;
    logic              finished_q;
    logic [ADDR_W-1:0] base_q, count_q, idx_q, ram_read_adr_q;
    logic [LAT_W-1:0]  lat_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ADDR_W-1:0] out_index_q;
    logic              out_last_q, out_valid_q;
    logic [ADDR_W-1:0] argmax_index_q;
    logic [DATA_W-1:0] argmax_value_q;
    logic              busy_q, done_q;

    logic              start, run_start, accept;
    logic [DATA_W-1:0] max_value;
    logic [ADDR_W-1:0] max_index;

    assign start     = acc_finished & ~finished_q;
    assign run_start = start && (state_q == ST_IDLE);
    assign accept    = out_valid_q && out_if.out_ready;

    argmax_tracker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_argmax (
        .clk       (clk),
        .reset     (reset),
        .clear     (run_start),
        .sample_en (accept),
        .value     (out_data_q),
        .index     (out_index_q),
        .max_value (max_value),
        .max_index (max_index)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            finished_q     <= 1'b0;
            base_q         <= '0;
            count_q        <= '0;
            idx_q          <= '0;
            ram_read_adr_q <= '0;
            lat_q          <= '0;
            out_data_q     <= '0;
            out_index_q    <= '0;
            out_last_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            argmax_index_q <= '0;
            argmax_value_q <= DATA_MIN;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            finished_q <= acc_finished;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q  <= acc_result_base;
                        count_q <= acc_result_count;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        if (acc_result_count != '0) begin
                            ram_read_adr_q <= acc_result_base;
                            state_q        <= ST_FETCH;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_FETCH: begin
                    lat_q   <= '0;
                    state_q <= ST_WAIT;
                end
                // The address was presented during FETCH; the word lands after RAM_LATENCY cycles.
                ST_WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        out_data_q  <= ram_read_data;
                        out_index_q <= idx_q;
                        out_last_q  <= (idx_q == count_q - ADDR_W'(1));
                        out_valid_q <= 1'b1;
                        state_q     <= ST_SEND;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (out_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q          <= idx_q + ADDR_W'(1);
                            ram_read_adr_q <= base_q + idx_q + ADDR_W'(1);
                            state_q        <= ST_FETCH;
                        end
                    end
                end
                // The tracker holds the final maximum here; publish it as the run closes.
                ST_DONE: begin
                    done_q         <= 1'b0;
                    busy_q         <= 1'b0;
                    argmax_index_q <= max_index;
                    argmax_value_q <= max_value;
                    state_q        <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram_read_adr     = ram_read_adr_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_index = out_index_q;
    assign out_if.out_last  = out_last_q;
    assign out_if.out_valid = out_valid_q;
    assign argmax_index     = argmax_index_q;
    assign argmax_value     = argmax_value_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_result_streamer.sv
// Bench for result_streamer: behavioural neuron RAM, word scoreboard fed by a
// queue-based model of each run, and argmax computed from the RAM contents.
module tb_result_streamer;

    localparam int LAT = 1;

    typedef struct {
        logic [7:0] data;
        logic [7:0] index;
        logic       last;
    } word_t;

    logic       clk = 1'b0;
    logic       reset, acc_finished, busy, done;
    logic [7:0] acc_result_base, acc_result_count, ram_read_adr, ram_read_data;
    logic [7:0] argmax_index, argmax_value;

    result_streamer_if #(.DATA_W(8), .ADDR_W(8)) sif ();

    result_streamer #(.DATA_W(8), .ADDR_W(8), .RAM_LATENCY(LAT)) dut (
        .clk              (clk),
        .reset            (reset),
        .acc_finished     (acc_finished),
        .acc_result_base  (acc_result_base),
        .acc_result_count (acc_result_count),
        .ram_read_adr     (ram_read_adr),
        .ram_read_data    (ram_read_data),
        .out_if           (sif),
        .argmax_index     (argmax_index),
        .argmax_value     (argmax_value),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    // Neuron RAM with LAT-cycle registered read path.
    logic [7:0] ram     [256];
    logic [7:0] rd_pipe [LAT];

    always @(posedge clk) begin
        rd_pipe[0] <= ram[ram_read_adr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_read_data = rd_pipe[LAT-1];

    int         checks = 0, errors = 0;
    int         done_cnt = 0, hs_cnt = 0, valid_cnt = 0, stall_cnt = 0, cyc = 0;
    int         hs_cyc[$];
    word_t      exp_q[$];
    logic [7:0] exp_am_idx, exp_am_val;
    logic [7:0] snap_idx = 8'h00, snap_val = 8'h80;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data, prev_index;
    logic       prev_last;

    // Observes the stream on the falling edge: transfers, stalls, done pulses, argmax stability.
    initial begin : monitor
        word_t w;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (sif.out_valid) valid_cnt++;
                if (prev_stall) begin
                    checks++;
                    if (!sif.out_valid || sif.out_data !== prev_data || sif.out_index !== prev_index
                        || sif.out_last !== prev_last) begin
                        errors++;
                        $display("FAIL sb_stall got v%0b %h/%0d/%0b want v1 %h/%0d/%0b", sif.out_valid,
                                 sif.out_data, sif.out_index, sif.out_last, prev_data, prev_index, prev_last);
                    end
                end
                if (sif.out_valid && sif.out_ready) begin
                    hs_cnt++;
                    hs_cyc.push_back(cyc);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra got word %h idx %0d want none", sif.out_data, sif.out_index);
                    end else begin
                        w = exp_q.pop_front();
                        if (sif.out_data !== w.data || sif.out_index !== w.index || sif.out_last !== w.last) begin
                            errors++;
                            $display("FAIL sb_word got %h/%0d/%0b want %h/%0d/%0b", sif.out_data,
                                     sif.out_index, sif.out_last, w.data, w.index, w.last);
                        end
                    end
                end
                prev_stall = sif.out_valid && !sif.out_ready;
                if (prev_stall) stall_cnt++;
                prev_data  = sif.out_data;
                prev_index = sif.out_index;
                prev_last  = sif.out_last;
                if (busy) begin
                    checks++;
                    if (argmax_index !== snap_idx || argmax_value !== snap_val) begin
                        errors++;
                        $display("FAIL argmax_stable got %0d/%h want %0d/%h", argmax_index, argmax_value,
                                 snap_idx, snap_val);
                    end
                end else begin
                    snap_idx = argmax_index;
                    snap_val = argmax_value;
                end
            end
        end
    end

    // Expected words and argmax for a run, straight from RAM contents.
    task automatic load_model(input logic [7:0] base, input logic [7:0] count);
        int best;
        best = -128;
        exp_am_idx = 8'h00;
        exp_q.delete();
        for (int i = 0; i < int'(count); i++) begin
            logic [7:0] a;
            logic [7:0] v;
            a = base + 8'(i);
            v = ram[a];
            exp_q.push_back('{data: v, index: 8'(i), last: (i == int'(count) - 1)});
            if (int'($signed(v)) > best) begin
                best       = int'($signed(v));
                exp_am_idx = 8'(i);
            end
        end
        exp_am_val = 8'(best);
    endtask

    task automatic clear_counters();
        done_cnt  = 0;
        hs_cnt    = 0;
        valid_cnt = 0;
        stall_cnt = 0;
        hs_cyc.delete();
    endtask

    // mode 0: ready high, 1: ready 1-of-3 cycles, 2: random. hold keeps finished high and re-pulses it mid-run.
    task automatic run_stream(input logic [7:0] base, input logic [7:0] count, input int mode,
                              input bit hold, output bit timed_out);
        load_model(base, count);
        clear_counters();
        acc_result_base  = base;
        acc_result_count = count;
        acc_finished     = 1'b1;
        @(posedge clk); #1;
        acc_result_base  = 8'($urandom);
        acc_result_count = 8'($urandom);
        if (!hold) acc_finished = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            case (mode)
                0:       sif.out_ready = 1'b1;
                1:       sif.out_ready = (c % 3 == 0);
                default: sif.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (hold && c == 5) acc_finished = 1'b0;
            if (hold && c == 6) acc_finished = 1'b1;
            @(posedge clk); #1;
            if (done_cnt != 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        acc_finished = 1'b0;
        acc_result_base = 8'h00;
        acc_result_count = 8'h00;
        sif.out_ready = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, sif.out_valid, sif.out_last} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {busy, done, sif.out_valid, sif.out_last});
        end
        checks++;
        if (argmax_value !== 8'h80 || argmax_index !== 8'h00) begin
            errors++;
            $display("FAIL reset_argmax got %0d/%h want 0/80", argmax_index, argmax_value);
        end
        checks++;
        if (ram_read_adr !== 8'h00 || sif.out_data !== 8'h00 || sif.out_index !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs got adr %h data %h idx %h want 00", ram_read_adr, sif.out_data, sif.out_index);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit to;
        ram[8'h10] = 8'd5; ram[8'h11] = 8'hFD; ram[8'h12] = 8'd9; ram[8'h13] = 8'd2;
        run_stream(8'h10, 8'd4, 0, 1'b0, to);
        checks++; if (to) begin errors++; $display("FAIL t1_timeout got no done want done"); end
        checks++; if (hs_cnt != 4 || exp_q.size() != 0) begin errors++; $display("FAIL t1_words got %0d want 4", hs_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL t1_done got %0d want 1", done_cnt); end
        checks++;
        if (argmax_index !== 8'd2 || argmax_value !== 8'd9) begin
            errors++;
            $display("FAIL t1_argmax got %0d/%h want 2/09", argmax_index, argmax_value);
        end
        for (int i = 1; i < hs_cyc.size(); i++) begin
            checks++;
            if (hs_cyc[i] - hs_cyc[i-1] != 2 + LAT) begin
                errors++;
                $display("FAIL t1_rate got %0d want %0d", hs_cyc[i] - hs_cyc[i-1], 2 + LAT);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (ram_read_adr !== 8'h13 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_idle got adr %h busy %b want 13 0", ram_read_adr, busy);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        run_stream(8'h10, 8'd4, 1, 1'b0, to);
        checks++; if (to) begin errors++; $display("FAIL t2_timeout got no done want done"); end
        checks++; if (hs_cnt != 4 || exp_q.size() != 0) begin errors++; $display("FAIL t2_words got %0d want 4", hs_cnt); end
        checks++; if (stall_cnt == 0) begin errors++; $display("FAIL t2_stalls got 0 want >0"); end
        checks++;
        if (done_cnt != 1 || argmax_index !== 8'd2 || argmax_value !== 8'd9) begin
            errors++;
            $display("FAIL t2_end got done %0d %0d/%h want 1 2/09", done_cnt, argmax_index, argmax_value);
        end
    endtask

    task automatic test_wrap();
        bit to;
        ram[8'hFE] = 8'hFF; ram[8'hFF] = 8'hF9; ram[8'h00] = 8'hFF;
        run_stream(8'hFE, 8'd3, 0, 1'b0, to);
        checks++; if (to) begin errors++; $display("FAIL t3_timeout got no done want done"); end
        checks++; if (hs_cnt != 3 || exp_q.size() != 0) begin errors++; $display("FAIL t3_words got %0d want 3", hs_cnt); end
        checks++;
        if (argmax_index !== 8'd0 || argmax_value !== 8'hFF) begin
            errors++;
            $display("FAIL t3_argmax got %0d/%h want 0/ff", argmax_index, argmax_value);
        end
        checks++; if (ram_read_adr !== 8'h00) begin errors++; $display("FAIL t3_adr got %h want 00", ram_read_adr); end
    endtask

    task automatic test_count_zero();
        clear_counters();
        acc_result_base  = 8'h33;
        acc_result_count = 8'h00;
        acc_finished     = 1'b1;
        @(posedge clk); #1;
        acc_finished = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t4_pulse got done %b busy %b want 1 1", done, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t4_end got done %b busy %b want 0 0", done, busy);
        end
        checks++;
        if (argmax_index !== 8'd0 || argmax_value !== 8'h80) begin
            errors++;
            $display("FAIL t4_argmax got %0d/%h want 0/80", argmax_index, argmax_value);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (valid_cnt != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL t4_quiet got valid %0d done %0d want 0 1", valid_cnt, done_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        bit to;
        bit hit;
        for (int i = 0; i < 4; i++) ram[8'h20 + i] = 8'($urandom);
        load_model(8'h20, 8'd4);
        clear_counters();
        acc_result_base  = 8'h20;
        acc_result_count = 8'd4;
        acc_finished     = 1'b1;
        sif.out_ready    = 1'b1;
        @(posedge clk); #1;
        acc_finished = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge clk); #1;
            hit = (hs_cnt >= 1);
        end
        checks++; if (!hit) begin errors++; $display("FAIL t5_first got no word want word 0"); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || sif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL t5_abort got busy %b valid %b want 0 0", busy, sif.out_valid);
        end
        reset = 1'b0;
        exp_q.delete();
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != 0 || argmax_value !== 8'h80) begin
            errors++;
            $display("FAIL t5_nodone got done %0d val %h want 0 80", done_cnt, argmax_value);
        end
        run_stream(8'h20, 8'd4, 0, 1'b0, to);
        checks++;
        if (to || hs_cnt != 4 || exp_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL t5_restart got to %0b words %0d done %0d want 0 4 1", to, hs_cnt, done_cnt);
        end
        checks++;
        if (argmax_index !== exp_am_idx || argmax_value !== exp_am_val) begin
            errors++;
            $display("FAIL t5_argmax got %0d/%h want %0d/%h", argmax_index, argmax_value, exp_am_idx, exp_am_val);
        end
    endtask

    task automatic test_retrigger();
        bit to;
        for (int i = 0; i < 4; i++) ram[8'h40 + i] = 8'($urandom);
        run_stream(8'h40, 8'd4, 0, 1'b1, to);
        checks++;
        if (to || hs_cnt != 4 || exp_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL t6_run got to %0b words %0d done %0d want 0 4 1", to, hs_cnt, done_cnt);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (hs_cnt != 4 || done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t6_single got words %0d done %0d busy %b want 4 1 0", hs_cnt, done_cnt, busy);
        end
        acc_finished = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit         to;
        logic [7:0] base, count;
        for (int r = 0; r < 10; r++) begin
            base  = 8'($urandom);
            count = 8'($urandom_range(0, 12));
            for (int i = 0; i < int'(count); i++) ram[base + 8'(i)] = 8'($urandom);
            run_stream(base, count, 2, 1'b0, to);
            checks++;
            if (to || hs_cnt != int'(count) || exp_q.size() != 0 || done_cnt != 1) begin
                errors++;
                $display("FAIL rnd_run%0d got to %0b words %0d done %0d want 0 %0d 1", r, to, hs_cnt, done_cnt, count);
            end
            checks++;
            if (argmax_index !== exp_am_idx || argmax_value !== exp_am_val) begin
                errors++;
                $display("FAIL rnd_argmax%0d got %0d/%h want %0d/%h", r, argmax_index, argmax_value,
                         exp_am_idx, exp_am_val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_count_zero();
        test_reset_mid_run();
        test_retrigger();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
